// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the CORDIC phase demodulator.
package cordic_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned INT_W  = 34;
    localparam int unsigned ITER_W = 5;

    // Q3.28 angle and gain constants
    localparam logic signed [DATA_W-1:0] PI      = 32'sd843314857;
    localparam logic signed [DATA_W-1:0] HALF_PI = 32'sd421657428;
    localparam logic signed [DATA_W-1:0] TWO_PI  = 32'sd1686629713;
    localparam logic signed [DATA_W-1:0] K       = 32'sd163007430;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREROT,
        ST_ITER,
        ST_DONE
    } state_e;

    // atan(2^-i) in Q3.28 radians, i = 0..27
    function automatic logic signed [DATA_W-1:0] atan_lut(input logic [ITER_W-1:0] idx);
        case (idx)
            5'd0:    atan_lut = 32'sd210828714;
            5'd1:    atan_lut = 32'sd124459457;
            5'd2:    atan_lut = 32'sd65760959;
            5'd3:    atan_lut = 32'sd33381290;
            5'd4:    atan_lut = 32'sd16755422;
            5'd5:    atan_lut = 32'sd8385879;
            5'd6:    atan_lut = 32'sd4193963;
            5'd7:    atan_lut = 32'sd2097109;
            5'd8:    atan_lut = 32'sd1048571;
            5'd9:    atan_lut = 32'sd524287;
            5'd10:   atan_lut = 32'sd262144;
            5'd11:   atan_lut = 32'sd131072;
            5'd12:   atan_lut = 32'sd65536;
            5'd13:   atan_lut = 32'sd32768;
            5'd14:   atan_lut = 32'sd16384;
            5'd15:   atan_lut = 32'sd8192;
            5'd16:   atan_lut = 32'sd4096;
            5'd17:   atan_lut = 32'sd2048;
            5'd18:   atan_lut = 32'sd1024;
            5'd19:   atan_lut = 32'sd512;
            5'd20:   atan_lut = 32'sd256;
            5'd21:   atan_lut = 32'sd128;
            5'd22:   atan_lut = 32'sd64;
            5'd23:   atan_lut = 32'sd32;
            5'd24:   atan_lut = 32'sd16;
            5'd25:   atan_lut = 32'sd8;
            5'd26:   atan_lut = 32'sd4;
            5'd27:   atan_lut = 32'sd2;
            default: atan_lut = '0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_phase_demod_phase_wrap_diff.sv
// Angle difference a - b folded back into (-PI, PI] with a single correction.
module phase_wrap_diff
    import cordic_pkg::*;
(
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] diff_c
);

    logic signed [DATA_W-1:0] raw_c;

    // Subtract, then wrap once; inputs are already within one turn of each other
    always_comb begin
        raw_c  = a_in - b_in;
        diff_c = raw_c;
        if (raw_c > PI) begin
            diff_c = raw_c - TWO_PI;
        end else if (raw_c <= -PI) begin
            diff_c = raw_c + TWO_PI;
        end
    end

endmodule

// File: rtl/cordic_phase_demod.sv
// Iterative vectoring-mode CORDIC: (x, y) -> phase, uncompensated magnitude, phase step.
module cordic_phase_demod
    import cordic_pkg::*;
#(
    parameter int unsigned ITER = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] y_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] phase_out,
    output logic        [DATA_W-1:0] mag_out,
    output logic signed [DATA_W-1:0] delta_out,
    output logic                     first_out
);

    state_e                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] phase_q, phase_d;
    logic        [DATA_W-1:0] mag_q, mag_d;
    logic signed [DATA_W-1:0] delta_q, delta_d;
    logic                     first_q, first_d;
    logic                     first_pend_q, first_pend_d;
    logic signed [DATA_W-1:0] prev_phase_q, prev_phase_d;
    logic signed [INT_W-1:0]  x_q, x_d;
    logic signed [INT_W-1:0]  y_q, y_d;
    logic signed [DATA_W-1:0] z_q, z_d;
    logic        [ITER_W-1:0] iter_q, iter_d;
    logic                     zero_q, zero_d;

    logic signed [DATA_W-1:0] atan_c;
    logic signed [INT_W-1:0]  x_sh_c, y_sh_c;
    logic signed [INT_W-1:0]  x_step_c, y_step_c;
    logic signed [DATA_W-1:0] z_step_c;
    logic signed [DATA_W-1:0] phase_fin_c;
    logic signed [DATA_W-1:0] delta_c;

    // One micro-rotation from the current registers, plus the final-phase fixups
    always_comb begin
        atan_c = atan_lut(iter_q);
        x_sh_c = x_q >>> iter_q;
        y_sh_c = y_q >>> iter_q;
        if (!y_q[INT_W-1]) begin
            x_step_c = x_q + y_sh_c;
            y_step_c = y_q - x_sh_c;
            z_step_c = z_q + atan_c;
        end else begin
            x_step_c = x_q - y_sh_c;
            y_step_c = y_q + x_sh_c;
            z_step_c = z_q - atan_c;
        end
        if (zero_q) begin
            phase_fin_c = '0;
        end else if (z_step_c <= -PI) begin
            phase_fin_c = PI;
        end else begin
            phase_fin_c = z_step_c;
        end
    end

    phase_wrap_diff u_wrap (
        .a_in   (phase_fin_c),
        .b_in   (prev_phase_q),
        .diff_c (delta_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        phase_d      = phase_q;
        mag_d        = mag_q;
        delta_d      = delta_q;
        first_d      = first_q;
        first_pend_d = first_pend_q;
        prev_phase_d = prev_phase_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        iter_d       = iter_q;
        zero_d       = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d        = INT_W'(x_in);
                    y_d        = INT_W'(y_in);
                    zero_d     = (x_in == '0) && (y_in == '0);
                    in_ready_d = 1'b0;
                    state_d    = ST_PREROT;
                end
            end
            ST_PREROT: begin
                // Fold left half-plane onto the right so the iterations converge
                if (x_q[INT_W-1]) begin
                    if (!y_q[INT_W-1]) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = HALF_PI;
                    end else begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = -HALF_PI;
                    end
                end else begin
                    z_d = '0;
                end
                iter_d  = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                x_d    = x_step_c;
                y_d    = y_step_c;
                z_d    = z_step_c;
                iter_d = iter_q + 5'd1;
                if (iter_q == ITER_W'(ITER - 1)) begin
                    phase_d      = phase_fin_c;
                    mag_d        = zero_q ? '0 : x_step_c[DATA_W-1:0];
                    delta_d      = first_pend_q ? '0 : delta_c;
                    first_d      = first_pend_q;
                    prev_phase_d = phase_fin_c;
                    first_pend_d = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            phase_q      <= '0;
            mag_q        <= '0;
            delta_q      <= '0;
            first_q      <= 1'b0;
            first_pend_q <= 1'b1;
            prev_phase_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            iter_q       <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            phase_q      <= phase_d;
            mag_q        <= mag_d;
            delta_q      <= delta_d;
            first_q      <= first_d;
            first_pend_q <= first_pend_d;
            prev_phase_q <= prev_phase_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            iter_q       <= iter_d;
            zero_q       <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign phase_out = phase_q;
    assign mag_out   = mag_q;
    assign delta_out = delta_q;
    assign first_out = first_q;

endmodule

// File: tb/tb_cordic_phase_demod.sv
// Self-checking bench for cordic_phase_demod: vector table, corner sequences, DDFS sweep, random.
module tb_cordic_phase_demod;

    localparam int unsigned ITER     = 24;
    localparam longint      PI_Q     = 843314857;
    localparam longint      TWO_PI_Q = 1686629713;
    localparam real         SCALE    = 268435456.0;
    localparam real         R_PI     = 3.14159265358979323846;
    localparam real         K_AMP    = 163007430.0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] phase_out;
    logic [31:0] mag_out;
    logic [31:0] delta_out;
    logic        first_out;

    int  n_tests = 0;
    int  n_fail  = 0;
    real gain;

    typedef struct {
        int     x;
        int     y;
        longint ph;
        longint mg;
        longint dl;
        bit     fst;
        int     ptol;
        int     mtol;
        int     dtol;
    } vec_t;

    vec_t vecs [9];

    cordic_phase_demod #(.ITER(ITER)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .phase_out (phase_out),
        .mag_out   (mag_out),
        .delta_out (delta_out),
        .first_out (first_out)
    );

    always #5 clk = ~clk;

    initial begin
        #(64'd20_000_000);
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1);
    end

    function automatic longint wrap_q(input longint d);
        longint r;
        r = d;
        while (r > PI_Q) r -= TWO_PI_Q;
        while (r <= -PI_Q) r += TWO_PI_Q;
        return r;
    endfunction

    function automatic longint model_phase(input int x, input int y);
        return longint'($atan2(real'(y), real'(x)) * SCALE);
    endfunction

    function automatic longint model_mag(input int x, input int y);
        real rx, ry;
        rx = real'(x);
        ry = real'(y);
        return longint'(gain * $sqrt(rx * rx + ry * ry));
    endfunction

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        longint d;
        d = act - exp;
        if (d < 0) d = -d;
        n_tests++;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic check_ang(input string name, input longint act, input longint exp, input longint tol);
        longint d;
        d = wrap_q(act - exp);
        if (d < 0) d = -d;
        n_tests++;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (tol %0d, wrapped)", name, act, exp, tol);
        end
    endtask

    task automatic run_sample(input int x, input int y, input bit eager,
                              output longint ph, output longint mg, output longint dl,
                              output bit fst, output int lat);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_wait", longint'(in_ready), 1, 0);
        in_valid  = 1'b1;
        x_in      = x;
        y_in      = y;
        out_ready = eager;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        ph  = longint'($signed(phase_out));
        mg  = longint'(mag_out);
        dl  = longint'($signed(delta_out));
        fst = first_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    longint ph, mg, dl, mp, mpk, hold_ph, hold_mg, hold_dl;
    bit     fst;
    int     lat;

    initial begin
        vecs[0] = '{268435456, 0, 0, 442048841, 0, 1'b1, 64, 64, 0};
        vecs[1] = '{0, 268435456, 421657428, 442048841, 421657428, 1'b0, 64, 128, 128};
        vecs[2] = '{-268435456, 0, 843314857, 442048841, 421657429, 1'b0, 64, 128, 128};
        vecs[3] = '{0, -268435456, -421657428, 442048841, 421657429, 1'b0, 64, 128, 128};
        vecs[4] = '{268435456, 268435456, 210828714, 625151465, 632486142, 1'b0, 64, 128, 128};
        vecs[5] = '{0, 0, 0, 0, -210828714, 1'b0, 0, 0, 128};
        vecs[6] = '{-268435456, -268435456, -632486143, 625151465, -632486143, 1'b0, 64, 128, 128};
        vecs[7] = '{-268435456, 0, 843314857, 442048841, -210828713, 1'b0, 64, 128, 128};
        vecs[8] = '{536870912, -536870912, -210828714, 1250302930, 632486142, 1'b0, 64, 256, 128};

        gain = 1.0;
        begin
            real p;
            p = 1.0;
            for (int i = 0; i < int'(ITER); i++) begin
                gain = gain * $sqrt(1.0 + p);
                p = p / 4.0;
            end
        end

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", longint'(in_ready), 1, 0);
        check("rst_out_valid", longint'(out_valid), 0, 0);
        check("rst_phase", longint'(phase_out), 0, 0);
        check("rst_mag", longint'(mag_out), 0, 0);
        check("rst_delta", longint'(delta_out), 0, 0);
        check("rst_first", longint'(first_out), 0, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            run_sample(vecs[i].x, vecs[i].y, 1'b0, ph, mg, dl, fst, lat);
            check($sformatf("vec%0d_latency", i), lat, ITER + 2, 0);
            check_ang($sformatf("vec%0d_phase", i), ph, vecs[i].ph, vecs[i].ptol);
            check($sformatf("vec%0d_mag", i), mg, vecs[i].mg, vecs[i].mtol);
            check_ang($sformatf("vec%0d_delta", i), dl, vecs[i].dl, vecs[i].dtol);
            check($sformatf("vec%0d_first", i), longint'(fst), longint'(vecs[i].fst), 0);
        end
        // The pi case must land on the positive side
        run_sample(-268435456, 0, 1'b0, ph, mg, dl, fst, lat);
        check("pi_positive", ph, PI_Q, 64);

        // Back-pressure in DONE: outputs frozen, new inputs ignored
        in_valid = 1'b1;
        x_in = 300000000;
        y_in = -100000000;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", lat, ITER + 2, 0);
        hold_ph = longint'($signed(phase_out));
        hold_mg = longint'(mag_out);
        hold_dl = longint'($signed(delta_out));
        check("bp_phase_model", hold_ph, model_phase(300000000, -100000000), 128);
        check("bp_mag_model", hold_mg, model_mag(300000000, -100000000), 128);
        for (int k = 0; k < 5; k++) begin
            in_valid = ~k[0];
            x_in = $urandom;
            y_in = $urandom;
            @(negedge clk);
            check("bp_out_valid", longint'(out_valid), 1, 0);
            check("bp_in_ready", longint'(in_ready), 0, 0);
            check("bp_phase_hold", longint'($signed(phase_out)), hold_ph, 0);
            check("bp_mag_hold", longint'(mag_out), hold_mg, 0);
            check("bp_delta_hold", longint'($signed(delta_out)), hold_dl, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", longint'(in_ready), 1, 0);
        check("bp_release_out_valid", longint'(out_valid), 0, 0);
        repeat (ITER + 4) @(negedge clk);
        check("bp_no_phantom", longint'(out_valid), 0, 0);

        // Reset in the middle of iteration 10
        in_valid = 1'b1;
        x_in = 200000000;
        y_in = 150000000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", longint'(out_valid), 0, 0);
        check("mid_rst_in_ready", longint'(in_ready), 1, 0);
        check("mid_rst_phase", longint'(phase_out), 0, 0);
        check("mid_rst_first", longint'(first_out), 0, 0);
        reset_n = 1'b1;
        repeat (ITER + 4) @(negedge clk);
        check("mid_rst_discard", longint'(out_valid), 0, 0);
        run_sample(268435456, 0, 1'b0, ph, mg, dl, fst, lat);
        check("post_rst_first", longint'(fst), 1, 0);
        check("post_rst_delta", dl, 0, 0);
        check("post_rst_phase", ph, 0, 64);

        // DDFS sweep at 1 degree per sample across the +-pi and 2pi wraps
        pulse_reset();
        mp = 0;
        for (int k = 1; k <= 720; k++) begin
            int xs, ys;
            bit ok;
            xs = int'(K_AMP * $cos(real'(k) * R_PI / 180.0));
            ys = int'(K_AMP * $sin(real'(k) * R_PI / 180.0));
            mpk = model_phase(xs, ys);
            run_sample(xs, ys, k[0], ph, mg, dl, fst, lat);
            if (k == 1) begin
                check("ddfs_first_flag", longint'(fst), 1, 0);
                check("ddfs_first_delta", dl, 0, 0);
            end else begin
                check_ang($sformatf("ddfs_delta_k%0d", k), dl, wrap_q(mpk - mp), 128);
            end
            check_ang($sformatf("ddfs_phase_k%0d", k), ph, mpk, 128);
            ok = (ph > -PI_Q) && (ph <= PI_Q + 64);
            check($sformatf("ddfs_range_k%0d", k), longint'(ok), 1, 0);
            mp = mpk;
        end

        // Randomized samples against the atan2 / hypot model
        for (int n = 0; n < 60; n++) begin
            int xs, ys;
            do begin
                xs = int'($urandom_range(1073741824, 0)) - 536870912;
                ys = int'($urandom_range(1073741824, 0)) - 536870912;
            end while ((xs < 134217728) && (xs > -134217728) &&
                       (ys < 134217728) && (ys > -134217728));
            mpk = model_phase(xs, ys);
            run_sample(xs, ys, n[1], ph, mg, dl, fst, lat);
            check_ang($sformatf("rnd%0d_phase", n), ph, mpk, 256);
            check($sformatf("rnd%0d_mag", n), mg, model_mag(xs, ys), 256);
            check_ang($sformatf("rnd%0d_delta", n), dl, wrap_q(mpk - mp), 512);
            check($sformatf("rnd%0d_first", n), longint'(fst), 0, 0);
            mp = mpk;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_phase_demod.md
# cordic_phase_demod

Iterative CORDIC vectoring-mode engine that converts a Q3.28 (x, y) sample pair into phase, magnitude, and sample-to-sample phase step. It is the receive-side counterpart of the DDFS sine/cosine generator: fed with COS/SIN words, it recovers the angle and the per-sample phase increment, such as 4685084 for 1°/sample. It sits behind a valid/ready sample source and in front of frequency-measurement or loop-filter logic.

## Interface
- ITER, default 24: number of micro-rotations; legal range 8..28.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  x_in/y_in are valid.
- in_ready  out  1  block can accept a sample.
- x_in  in  32  signed Q3.28 cosine / I component; |x_in| ≤ 2.0 (536870912).
- y_in  in  32  signed Q3.28 sine / Q component; |y_in| ≤ 2.0.
- out_valid  out  1  results are valid.
- out_ready  in  1  consumer accepts the results.
- phase_out  out  32  signed Q3.28 atan2(y,x) in radians, range (−π, π].
- mag_out  out  32  unsigned-valued Q3.28 magnitude × CORDIC gain (≈1.64676); not compensated.
- delta_out  out  32  signed Q3.28 phase_out minus previous phase_out, wrapped into (−π, π].
- first_out  out  1  first result since reset; delta_out is 0 on this result.

## Operation
- FSM states: IDLE, PREROT, ITER, DONE.
- IDLE: in_ready=1. When in_valid is high, capture x/y, sign-extended to 34-bit internal registers; next state is PREROT.
- PREROT, quadrant fold with z initialised:
  - x ≥ 0: unchanged, z=0.
  - x < 0 and y ≥ 0: (x,y) ← (y,−x), z=+HALF_PI.
  - x < 0 and y < 0: (x,y) ← (−y,x), z=−HALF_PI.
  - Next state is ITER with i=0.
- ITER, step i (shifts are arithmetic):
  - y ≥ 0: x += y>>>i, y −= x>>>i, z += ATAN[i].
  - y < 0: x −= y>>>i, y += x>>>i, z −= ATAN[i].
  - All updates use the pre-step values.
  - After step ITER−1, go to DONE.
- DONE:
  - Register phase_out=z and mag_out=x[31:0].
  - delta_out = z − prev_phase, then wrap: if d > PI, subtract TWO_PI; if d ≤ −PI, add TWO_PI.
  - If first_pending, delta_out=0.
  - Then update prev_phase and clear first_pending.
  - out_valid=1. Hold all outputs until out_ready; on the handshake, return to IDLE.
- Zero input (x=y=0): phase_out=0 and mag_out=0, forced in DONE. The delta follows the normal rules.
- Phase π: the x<0, y=0 case yields ≈+PI and must never yield −PI. A final z ≤ −PI is mapped to +PI.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - phase_out, mag_out, delta_out = 0.
  - first_out=0, first_pending=1, prev_phase=0.
- Latency from the input handshake cycle to out_valid high is ITER+2 cycles (1 PREROT, ITER iterations, 1 DONE register).
- in_ready is low from the cycle after acceptance until the cycle after the output handshake.
- Best-case throughput is one sample per ITER+3 cycles.
- out_valid stays high and outputs stay stable while out_ready=0; there is no timeout.
- out_ready high while out_valid=0 is ignored.
- Reset asserted in any state takes effect at the next edge: the sample in flight is discarded, first_pending=1, and outputs return to their reset values.
- Internal x/y are 34 bits; the input bound guarantees no overflow (max ≈ 1.647 × 2.83 × 2^28).

## Structure
- Package cordic_pkg holds:
  - Q3.28 constants: PI=843314857, HALF_PI=421657428, TWO_PI=1686629713, K=163007430.
  - ATAN table of 28 entries (ATAN[0]=210828714).
  - The state enum.
- Sub-module phase_wrap_diff: combinational, 32-bit subtract plus single wrap correction. It produces delta_out, is instantiated once, and is reusable by a later frequency estimator.

## Test plan
- (268435456, 0): phase_out 0 ±64, mag_out 442048841 ±64, first_out=1, delta_out=0, out_valid at cycle ITER+2.
- (0, 268435456), then (−268435456, 0): phase_out 421657428 ±64, then +843314857 ±64; second delta_out 421657429 ±128.
- 720 DDFS samples (K·cos k°, K·sin k°) at k=1,2,…: every delta_out after the first is 4685084 ±128, including across the 180° and 360° wraps; phase_out stays within (−π, π].
- (0, 0): phase_out 0, mag_out 0, no X/overflow.
- Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0, and in_valid pulses ignored. Release: handshake, then in_ready=1 next cycle.
- reset_n low for one cycle at iteration 10: next edge gives out_valid=0 and in_ready=1; the next sample returns first_out=1 and delta_out=0.
